telemetry_rx: RTL
=================

# telemetry_rx

Bench-side and display-side UART receiver for the e-bike telemetry stream, the counterpart of the sensor-conditioning telemetry transmitter. It deserializes the 8-byte telemetry packet from the TX line and recovers the three 12-bit fields: battery voltage, average current and average torque. It presents the fields atomically with a one-cycle valid strobe. It sits on the dashboard/test-harness side of the single serial wire.

## Interface
Parameters:
- BAUD_DIV, default 2604: clocks per bit; 50 MHz / 19200 baud. Minimum value is 8.
- FAST_SIM, default 1: when 1, the timeout limit (see Configuration) is 20×BAUD_DIV/16 instead of 20×BAUD_DIV.

Ports:
- clk  in  1: system clock; the block's only clock.
- rst  in  1: reset, synchronous and active-high.
- RX  in  1: serial input, idle high; asynchronous to clk.
- batt_v  out  12: last accepted battery voltage.
- avg_curr  out  12: last accepted average current.
- avg_torque  out  12: last accepted average torque.
- pkt_vld  out  1: one-cycle pulse when a complete packet is accepted.
- err_cnt  out  8: saturating count of rejected bytes and packets.

## Operation
- Packet format, 8 bytes, each byte sent LSB first with 1 start bit and 1 stop bit:
  - bytes 0–1: 0xAA, 0x55.
  - bytes 2–7: {4'h0,batt_v[11:8]}, batt_v[7:0], {4'h0,avg_curr[11:8]}, avg_curr[7:0], {4'h0,avg_torque[11:8]}, avg_torque[7:0].
- Input synchronization: RX passes through two flops. Both flops reset to 1.
- Bit engine states:
  - IDLE: a falling edge on the synced RX moves to START.
  - START: wait BAUD_DIV/2 clocks, then sample RX. If RX=1, this was a false start; return to IDLE. If RX=0, go to DATA.
  - DATA: sample 8 bits, one every BAUD_DIV clocks, LSB first; then go to STOP.
  - STOP: after BAUD_DIV clocks, sample RX. RX=1 issues a byte strobe. RX=0 is a framing error. Either way, return to IDLE.
- Framer states:
  - HUNT_AA: a byte of 0xAA moves to HUNT_55. Any other byte is discarded silently.
  - HUNT_55: 0x55 moves to FIELD with idx=0. 0xAA stays in HUNT_55 (resync). Any other byte returns to HUNT_AA.
  - FIELD: bytes are stored into a shadow register by idx (0–5).
    - Even idx (high byte) with a nonzero upper nibble is a format error: go to HUNT_AA.
    - At idx=5, the shadow register is copied to all three outputs in the same cycle, pkt_vld pulses, and the framer returns to HUNT_AA.
- Framing error in any framer state: the byte is discarded, the framer goes to HUNT_AA and err_cnt increments.
- Format error: err_cnt increments.
- err_cnt saturates at 8'hFF.
- Outputs hold their values between packets. A partial packet never modifies them.

## Timing
- Reset values: batt_v, avg_curr, avg_torque = 0; pkt_vld = 0; err_cnt = 0. Both engines are in IDLE/HUNT_AA.
- Reset mid-byte or mid-packet abandons all progress. The next packet must start with 0xAA.
- Sample points fall at BAUD_DIV/2 + k·BAUD_DIV clocks after the synced falling edge, k = 0..9.
- pkt_vld and the new output values appear on the clock edge after the stop-bit sample of byte 7. That is 1 cycle of latency from the sample, and 2 synchronizer cycles plus 9.5·BAUD_DIV cycles from the start edge of that byte.
- Any error detected on a byte and the resulting err_cnt increment also take effect 1 cycle after that byte's stop-bit sample.
- Back-to-back bytes with zero idle time are supported: a new start edge is detected immediately after STOP returns to IDLE.
- pkt_vld is never high for two consecutive cycles.

## Configuration
- Macro TELEM_RX_TIMEOUT_EN.
- Defined:
  - An inter-byte idle counter runs while the framer is not in HUNT_AA. It clears on every byte strobe.
  - The limit is 20×BAUD_DIV, or 20×BAUD_DIV/16 when FAST_SIM=1.
  - When the counter reaches the limit, the framer returns to HUNT_AA and err_cnt increments once.
- Not defined: no counter is built. The framer waits indefinitely for the remaining bytes.

## Test plan
Run all scenarios with BAUD_DIV=16.
- Reset, then send AA 55 0A 98 03 21 07 FF → batt_v=12'hA98, avg_curr=12'h321, avg_torque=12'h7FF. pkt_vld pulses exactly once, 1 cycle after the last stop sample. err_cnt=0.
- Send 3C AA AA 55 followed by the 6 field bytes of the previous packet → the packet is accepted. err_cnt stays 0.
- Send a valid packet whose byte 4 has stop bit = 0, then send a good packet with fields 0x123/0x456/0x789 → the first packet is not accepted; err_cnt=1 and outputs hold their prior values. The second packet is accepted with the new values.
- Send AA 55 1A 98 03 21 07 FF → no pkt_vld, err_cnt increments by 1, outputs unchanged.
- Drive RX low for 5 clocks, then return it high → no byte strobe and no err_cnt change. Then send a good packet → it is accepted normally.
- With TELEM_RX_TIMEOUT_EN defined and FAST_SIM=0: send AA 55 0A, idle 400 clocks, then send a full good packet → err_cnt=1 and the packet is accepted. Without the macro, the same stimulus gives no timeout; the framer consumes the new AA/55 as field bytes and reports a format error.

Source files
------------

// File: rtl/telemetry_rx.sv
// UART receiver and packet framer for the e-bike telemetry stream (AA 55 + three 12-bit fields).
// Optional inter-byte idle timeout is built when TELEM_RX_TIMEOUT_EN is defined.
module telemetry_rx #(
    parameter int BAUD_DIV = 2604,
    parameter int FAST_SIM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic [11:0] batt_v,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        pkt_vld,
    output logic [7:0]  err_cnt
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [1:0] {HUNT_AA, HUNT_55, FIELD} frame_state_t;

    logic rx_meta, rx_sync, rx_prev, rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    bit_state_t      bit_state, bit_next;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_byte;
    logic            cnt_clr, shift_en, byte_stb, frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_state <= B_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            rx_byte   <= '0;
        end else begin
            bit_state <= bit_next;
            cnt       <= cnt_clr ? '0 : cnt + 1'b1;
            if (bit_state == B_START)
                bit_idx <= '0;
            else if (shift_en)
                bit_idx <= bit_idx + 1'b1;
            if (shift_en)
                rx_byte <= {rx_sync, rx_byte[7:1]};
        end
    end

    always_comb begin
        bit_next  = bit_state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        byte_stb  = 1'b0;
        frame_err = 1'b0;
        case (bit_state)
            B_IDLE: begin
                cnt_clr = 1'b1;
                if (rx_fall)
                    bit_next = B_START;
            end
            B_START: begin
                if (cnt == HALF_M1) begin
                    cnt_clr  = 1'b1;
                    bit_next = rx_sync ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7)
                        bit_next = B_STOP;
                end
            end
            B_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_clr   = 1'b1;
                    bit_next  = B_IDLE;
                    byte_stb  = rx_sync;
                    frame_err = ~rx_sync;
                end
            end
            default: bit_next = B_IDLE;
        endcase
    end

    frame_state_t fr_state, fr_next;
    logic [2:0]   idx;
    logic [3:0]   sh_batt_hi, sh_curr_hi, sh_torq_hi;
    logic [7:0]   sh_batt_lo, sh_curr_lo;
    logic         fmt_err, to_err, commit, store, idx_clr, timeout;

`ifdef TELEM_RX_TIMEOUT_EN
    localparam int TO_LIMIT = (FAST_SIM != 0) ? (20 * BAUD_DIV) / 16 : 20 * BAUD_DIV;
    localparam int TW = $clog2(TO_LIMIT + 1);
    logic [TW-1:0] idle_cnt;

    // Counts clocks since the last good byte while a packet is in progress.
    always_ff @(posedge clk) begin
        if (rst || byte_stb || fr_state == HUNT_AA)
            idle_cnt <= '0;
        else if (idle_cnt != TW'(TO_LIMIT))
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout = (fr_state != HUNT_AA) && (idle_cnt == TW'(TO_LIMIT));
`else
    logic unused_fast_sim;
    assign unused_fast_sim = (FAST_SIM != 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        fr_next = fr_state;
        fmt_err = 1'b0;
        to_err  = 1'b0;
        commit  = 1'b0;
        store   = 1'b0;
        idx_clr = 1'b0;
        if (frame_err) begin
            fr_next = HUNT_AA;
        end else if (byte_stb) begin
            case (fr_state)
                HUNT_AA: begin
                    if (rx_byte == 8'hAA)
                        fr_next = HUNT_55;
                end
                HUNT_55: begin
                    if (rx_byte == 8'h55) begin
                        fr_next = FIELD;
                        idx_clr = 1'b1;
                    end else if (rx_byte != 8'hAA) begin
                        fr_next = HUNT_AA;
                    end
                end
                FIELD: begin
                    // High bytes carry only a nibble; anything above it means a corrupt stream.
                    if (!idx[0] && rx_byte[7:4] != 4'h0) begin
                        fmt_err = 1'b1;
                        fr_next = HUNT_AA;
                    end else if (idx == 3'd5) begin
                        commit  = 1'b1;
                        fr_next = HUNT_AA;
                    end else begin
                        store = 1'b1;
                    end
                end
                default: fr_next = HUNT_AA;
            endcase
        end else if (timeout) begin
            to_err  = 1'b1;
            fr_next = HUNT_AA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fr_state   <= HUNT_AA;
            idx        <= '0;
            sh_batt_hi <= '0;
            sh_batt_lo <= '0;
            sh_curr_hi <= '0;
            sh_curr_lo <= '0;
            sh_torq_hi <= '0;
            batt_v     <= '0;
            avg_curr   <= '0;
            avg_torque <= '0;
            pkt_vld    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            fr_state <= fr_next;
            pkt_vld  <= commit;
            if (idx_clr)
                idx <= '0;
            else if (store)
                idx <= idx + 1'b1;
            if (store) begin
                case (idx)
                    3'd0: sh_batt_hi <= rx_byte[3:0];
                    3'd1: sh_batt_lo <= rx_byte;
                    3'd2: sh_curr_hi <= rx_byte[3:0];
                    3'd3: sh_curr_lo <= rx_byte;
                    3'd4: sh_torq_hi <= rx_byte[3:0];
                    default: ;
                endcase
            end
            if (commit) begin
                batt_v     <= {sh_batt_hi, sh_batt_lo};
                avg_curr   <= {sh_curr_hi, sh_curr_lo};
                avg_torque <= {sh_torq_hi, rx_byte};
            end
            if ((frame_err || fmt_err || to_err) && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
